memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_if.sv | 31 +++
 rtl/memory_responder.sv | 108 ++++++++++
 tb/tb_memory_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
// Requester-to-memory handshake bundle for memory_responder.
// The master drives the request side and the slave answers with data and status.
interface memory_responder_if;
    logic        i_MIO_EN;
    logic        i_RW;
    logic [15:0] i_Addr;
    logic [15:0] i_Data;
    logic [15:0] o_Data;
    logic        o_Ready_Bit;
    logic        o_Busy;

    modport master (
        output i_MIO_EN,
        output i_RW,
        output i_Addr,
        output i_Data,
        input  o_Data,
        input  o_Ready_Bit,
        input  o_Busy
    );

    modport slave (
        input  i_MIO_EN,
        input  i_RW,
        input  i_Addr,
        input  i_Data,
        output o_Data,
        output o_Ready_Bit,
        output o_Busy
    );
endinterface

// File: rtl/memory_responder.sv
// Wait-state memory responder: latches a request, counts WAIT_CYCLES, then commits
// a write or returns read data together with a one-cycle ready strobe.
module memory_responder #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic              i_CLK,
    input  logic              i_Reset,
    memory_responder_if.slave bus
);
    localparam int unsigned Words = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StReady
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [15:0]          addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [15:0]          rdata_q, rdata_d;
    logic                 mem_we;
    logic                 in_range;
    logic [ADDR_BITS-1:0] mem_idx;
    logic [15:0]          mem_q [Words];

    if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end

    // Range check uses the latched address so mid-access input changes cannot leak in.
    assign in_range = (addr_q >> ADDR_BITS) == 16'h0000;
    assign mem_idx  = addr_q[ADDR_BITS-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_MIO_EN) begin
                    addr_d  = bus.i_Addr;
                    rw_d    = bus.i_RW;
                    wdata_d = bus.i_Data;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!bus.i_MIO_EN) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StReady;
                        if (rw_q) begin
                            mem_we = in_range;
                        end else begin
                            rdata_d = in_range ? mem_q[mem_idx] : 16'h0000;
                        end
                    end
                end
            end
            StReady: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            rw_q    <= 1'b0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge i_CLK) begin
        if (!i_Reset && mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    assign bus.o_Data      = rdata_q;
    assign bus.o_Ready_Bit = (state_q == StReady);
    assign bus.o_Busy      = (state_q != StIdle);
endmodule

// File: tb/tb_memory_responder.sv
// Randomized scoreboard bench for memory_responder: a driver issues accesses and
// queues expected responses; a monitor checks each ready strobe against the queue.
module tb_memory_responder;
    localparam int unsigned W  = 3;
    localparam int unsigned AB = 12;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    memory_responder_if bus ();

    memory_responder #(
        .ADDR_BITS  (AB),
        .WAIT_CYCLES(W)
    ) dut (
        .i_CLK  (clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          rdy_cyc;
        logic        is_rd;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model[int];
    logic [15:0] last_rd;
    int          n_cmp  = 0;
    int          n_fail = 0;

    logic [15:0] pool[12] = '{16'h0000, 16'h0010, 16'h0011, 16'h0020, 16'h0030, 16'h0040,
                              16'h0FFF, 16'h0123, 16'h0ABC, 16'h07FE, 16'h3000, 16'hF00F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit addr_ok(input logic [15:0] a);
        return int'(a) < (1 << AB);
    endfunction

    // Monitor: every ready strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.o_Ready_Bit) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'(bus.o_Ready_Bit), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.rdy_cyc));
                check(e.is_rd ? "read_data" : "data_after_write", 32'(bus.o_Data),
                      32'(e.data));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the ready strobe.
    task automatic access(input logic rw, input logic [15:0] a, input logic [15:0] d,
                          input bit scramble, input bit hold);
        exp_t e;
        bit   seen;
        bus.i_MIO_EN = 1'b1;
        bus.i_RW     = rw;
        bus.i_Addr   = a;
        bus.i_Data   = d;
        e.rdy_cyc    = cyc + 1 + int'(W);
        e.is_rd      = !rw;
        if (!rw) begin
            last_rd = addr_ok(a) ? model[int'(a)] : 16'h0000;
            e.data  = last_rd;
        end else begin
            e.data = last_rd;
            if (addr_ok(a)) model[int'(a)] = d;
        end
        sb_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < int'(W) + 4 && !seen; k++) begin
            @(negedge clk);
            if (bus.o_Ready_Bit) seen = 1'b1;
            else if (scramble && k >= 1) begin
                bus.i_Addr = 16'h0020;
                bus.i_Data = 16'hFFFF;
            end
        end
        if (!seen) check("ready_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.i_MIO_EN = 1'b0;
    endtask

    // Drops the request after k BUSY cycles (k < W), so the access never completes.
    task automatic abort(input logic rw, input logic [15:0] a, input logic [15:0] d,
                         input int k);
        bus.i_MIO_EN = 1'b1;
        bus.i_RW     = rw;
        bus.i_Addr   = a;
        bus.i_Data   = d;
        @(posedge clk);
        #1;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        bus.i_MIO_EN = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_low", 32'(bus.o_Busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.i_MIO_EN = 1'b1;
        bus.i_RW     = 1'b1;
        bus.i_Addr   = 16'h0010;
        bus.i_Data   = 16'hAAAA;
        last_rd      = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        bus.i_MIO_EN = 1'b0;
        rst          = 1'b0;
        check("reset_data", 32'(bus.o_Data), 32'd0);
        check("reset_ready", 32'(bus.o_Ready_Bit), 32'd0);
        check("reset_busy", 32'(bus.o_Busy), 32'd0);

        // Give every in-range pool word a known value.
        foreach (pool[i]) begin
            if (addr_ok(pool[i])) access(1'b1, pool[i], 16'($urandom), 1'b0, 1'b0);
        end

        access(1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0);
        access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
        access(1'b1, 16'h0011, 16'h5678, 1'b1, 1'b0);
        access(1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0);
        access(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
        abort(1'b1, 16'h0030, 16'hBEEF, 0);
        access(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0);
        access(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0);
        access(1'b1, 16'h3000, 16'h5A5A, 1'b0, 1'b0);
        access(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        access(1'b1, 16'h0010, 16'hC0DE, 1'b0, 1'b1);
        access(1'b0, 16'h0FFF, 16'h0000, 1'b0, 1'b0);
        access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);

        // Reset in the middle of a write's BUSY phase.
        bus.i_MIO_EN = 1'b1;
        bus.i_RW     = 1'b1;
        bus.i_Addr   = 16'h0040;
        bus.i_Data   = 16'hDEAD;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_busy", 32'(bus.o_Busy), 32'd0);
        check("midreset_ready", 32'(bus.o_Ready_Bit), 32'd0);
        check("midreset_data", 32'(bus.o_Data), 32'd0);
        rst     = 1'b0;
        last_rd = 16'h0000;
        access(1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            int          r;
            logic [15:0] a;
            r = int'($urandom_range(0, 9));
            a = pool[$urandom_range(0, 11)];
            if (r == 0) begin
                abort(1'($urandom), a, 16'($urandom), int'($urandom_range(0, W - 1)));
            end else begin
                access(1'($urandom), a, 16'($urandom), r == 1, 1'($urandom));
                if (bus.i_MIO_EN == 1'b0) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        end

        bus.i_MIO_EN = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        if (sb_q.size() != 0) check("pending_responses", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
